// File: rtl/uart_p_pkg.sv
// Shared types and constants for the uart_core_p UART core:
// parity modes, TX/RX FSM states and oversampling constants.
package uart_p_pkg;

    typedef enum logic [1:0] {
        PAR_NONE  = 2'b00,
        PAR_ODD   = 2'b01,
        PAR_EVEN  = 2'b10,
        PAR_SPACE = 2'b11
    } parity_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    localparam int OVS        = 16;
    localparam int MID_SAMPLE = 8;

    // Parity bit that goes on the wire, given the XOR of the data bits.
    function automatic logic parity_bit(input parity_t mode, input logic data_xor);
        case (mode)
            PAR_ODD:  return ~data_xor;
            PAR_EVEN: return data_xor;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous show-ahead FIFO with occupancy count, used for both UART directions.
// A push while full is accepted only when a pop happens in the same cycle.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         wr_en,
    input  logic                         rd_en,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_rd;
    logic             do_wr;

    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Storage has no reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_core_p.sv
// Parametrised single-clock UART core: baud tick generator, TX/RX FIFOs, parity and stop options.
// Optional RTS/CTS flow control is enabled by defining UART_FLOW_CTRL_EN.
module uart_core_p
    import uart_p_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16,
    parameter int DIV_W    = 16
) (
    input  logic                              Clk,
    input  logic                              Rst,
    input  logic [DIV_W-1:0]                  cfg_div,
    input  logic [1:0]                        cfg_parity,
    input  logic                              cfg_stop2,
    input  logic                              cfg_loop,
    input  logic [DATA_W-1:0]                 tx_data,
    input  logic                              tx_valid,
    output logic                              tx_ready,
    output logic [DATA_W-1:0]                 rx_data,
    output logic                              rx_valid,
    input  logic                              rx_ready,
    output logic [$clog2(TX_DEPTH+1)-1:0]     tx_count,
    output logic [$clog2(RX_DEPTH+1)-1:0]     rx_count,
    output logic                              tx_idle,
    output logic                              err_parity,
    output logic                              err_frame,
    output logic                              err_overrun,
    input  logic                              err_clr,
`ifdef UART_FLOW_CTRL_EN
    input  logic                              cts_n,
    output logic                              rts_n,
`endif
    output logic                              TX,
    input  logic                              RX
);

    localparam int             RXC_W     = $clog2(RX_DEPTH+1);
    localparam logic [3:0]     TICK_LAST = 4'(OVS-1);
    localparam logic [3:0]     TICK_MID  = 4'(MID_SAMPLE-1);
    localparam logic [3:0]     BIT_LAST  = 4'(DATA_W-1);

    logic [DIV_W-1:0]  div_cnt;
    logic              tick;
    logic              cts_ok;

    logic              tx_full, tx_empty, tx_pop;
    logic [DATA_W-1:0] tx_head;
    tx_state_t         tx_state, tx_state_n;
    logic [3:0]        tx_tick, tx_tick_n, tx_bit, tx_bit_n;
    logic [DATA_W-1:0] tx_shift, tx_shift_n;
    logic              tx_par, tx_par_n, tx_stop2, tx_stop2_n;
    parity_t           tx_mode, tx_mode_n;
    logic              tx_line, tx_launch, tx_bit_end;

    logic              rx_full, rx_empty, rx_pop, rx_push;
    logic [2:0]        rx_sync;
    logic              rx_s, rx_fall;
    rx_state_t         rx_state, rx_state_n;
    logic [3:0]        rx_tick, rx_tick_n, rx_bit, rx_bit_n;
    logic [DATA_W-1:0] rx_shift, rx_shift_n;
    logic              rx_pbit, rx_pbit_n;
    parity_t           rx_mode, rx_mode_n;
    logic              rx_sample, rx_bit_end;
    logic              set_par, set_frame, set_ovr;

    assign tick = (div_cnt == cfg_div);

    always_ff @(posedge Clk) begin
        if (Rst) div_cnt <= '0;
        else     div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
    end

`ifdef UART_FLOW_CTRL_EN
    logic [1:0] cts_sync;

    // CTS resets to "not clear" so nothing launches until the far end is seen ready.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            cts_sync <= 2'b11;
            rts_n    <= 1'b1;
        end else begin
            cts_sync <= {cts_sync[0], cts_n};
            rts_n    <= (rx_count >= RXC_W'(RX_DEPTH-2));
        end
    end

    assign cts_ok = !cts_sync[1];
`else
    assign cts_ok = 1'b1;
`endif

    uart_sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk     (Clk),
        .rst     (Rst),
        .wr_data (tx_data),
        .wr_en   (tx_valid && tx_ready),
        .rd_en   (tx_pop),
        .rd_data (tx_head),
        .full    (tx_full),
        .empty   (tx_empty),
        .count   (tx_count)
    );

    assign tx_ready = !tx_full;
    assign tx_idle  = tx_empty && (tx_state == TX_IDLE);
    assign TX       = cfg_loop ? 1'b1 : tx_line;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            tx_state <= TX_IDLE;
            tx_tick  <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            tx_stop2 <= 1'b0;
            tx_mode  <= PAR_NONE;
        end else begin
            tx_state <= tx_state_n;
            tx_tick  <= tx_tick_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            tx_par   <= tx_par_n;
            tx_stop2 <= tx_stop2_n;
            tx_mode  <= tx_mode_n;
        end
    end

    // The 4-bit tick counter wraps at OVS, so every state boundary starts it back at 0.
    always_comb begin
        tx_state_n = tx_state;
        tx_tick_n  = tx_tick;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_par_n   = tx_par;
        tx_stop2_n = tx_stop2;
        tx_mode_n  = tx_mode;
        tx_pop     = 1'b0;
        tx_line    = 1'b1;
        tx_launch  = 1'b0;
        tx_bit_end = tick && (tx_tick == TICK_LAST);

        if (tick && tx_state != TX_IDLE) tx_tick_n = tx_tick + 4'd1;

        case (tx_state)
            TX_IDLE: tx_launch = tick && !tx_empty && cts_ok;
            TX_START: begin
                tx_line = 1'b0;
                if (tx_bit_end) tx_state_n = TX_DATA;
            end
            TX_DATA: begin
                tx_line = tx_shift[0];
                if (tx_bit_end) begin
                    tx_shift_n = tx_shift >> 1;
                    if (tx_bit == BIT_LAST) begin
                        tx_bit_n   = '0;
                        tx_state_n = (tx_mode == PAR_NONE) ? TX_STOP : TX_PARITY;
                    end else begin
                        tx_bit_n = tx_bit + 4'd1;
                    end
                end
            end
            TX_PARITY: begin
                tx_line = tx_par;
                if (tx_bit_end) tx_state_n = TX_STOP;
            end
            TX_STOP: begin
                if (tx_bit_end) begin
                    if (tx_stop2 && tx_bit == '0) begin
                        tx_bit_n = 4'd1;
                    end else begin
                        tx_state_n = TX_IDLE;
                        tx_launch  = !tx_empty && cts_ok;
                    end
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase

        // Frame configuration is captured here so mid-frame changes wait for the next frame.
        if (tx_launch) begin
            tx_pop     = 1'b1;
            tx_state_n = TX_START;
            tx_tick_n  = '0;
            tx_bit_n   = '0;
            tx_shift_n = tx_head;
            tx_mode_n  = parity_t'(cfg_parity);
            tx_stop2_n = cfg_stop2;
            tx_par_n   = parity_bit(parity_t'(cfg_parity), ^tx_head);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) rx_sync <= 3'b111;
        else     rx_sync <= {rx_sync[1:0], cfg_loop ? tx_line : RX};
    end

    assign rx_s    = rx_sync[1];
    assign rx_fall = rx_sync[2] && !rx_s;

    uart_sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk     (Clk),
        .rst     (Rst),
        .wr_data (rx_shift),
        .wr_en   (rx_push),
        .rd_en   (rx_ready),
        .rd_data (rx_data),
        .full    (rx_full),
        .empty   (rx_empty),
        .count   (rx_count)
    );

    assign rx_valid = !rx_empty;
    assign rx_pop   = rx_valid && rx_ready;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            rx_state <= RX_IDLE;
            rx_tick  <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_pbit  <= 1'b0;
            rx_mode  <= PAR_NONE;
        end else begin
            rx_state <= rx_state_n;
            rx_tick  <= rx_tick_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
            rx_pbit  <= rx_pbit_n;
            rx_mode  <= rx_mode_n;
        end
    end

    // Bits are sampled mid-bit; the FSM leaves STOP right at the sample to catch a tight next start.
    always_comb begin
        rx_state_n = rx_state;
        rx_tick_n  = rx_tick;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_pbit_n  = rx_pbit;
        rx_mode_n  = rx_mode;
        rx_push    = 1'b0;
        set_par    = 1'b0;
        set_frame  = 1'b0;
        set_ovr    = 1'b0;
        rx_sample  = tick && (rx_tick == TICK_MID);
        rx_bit_end = tick && (rx_tick == TICK_LAST);

        if (tick && rx_state != RX_IDLE) rx_tick_n = rx_tick + 4'd1;

        case (rx_state)
            RX_IDLE: begin
                if (rx_fall) begin
                    rx_state_n = RX_START;
                    rx_tick_n  = '0;
                    rx_bit_n   = '0;
                    rx_mode_n  = parity_t'(cfg_parity);
                end
            end
            RX_START: begin
                if (rx_sample && rx_s) begin
                    rx_state_n = RX_IDLE;
                    rx_tick_n  = '0;
                end else if (rx_bit_end) begin
                    rx_state_n = RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_sample) rx_shift_n = {rx_s, rx_shift[DATA_W-1:1]};
                if (rx_bit_end) begin
                    if (rx_bit == BIT_LAST) begin
                        rx_bit_n   = '0;
                        rx_state_n = (rx_mode == PAR_NONE) ? RX_STOP : RX_PARITY;
                    end else begin
                        rx_bit_n = rx_bit + 4'd1;
                    end
                end
            end
            RX_PARITY: begin
                if (rx_sample)  rx_pbit_n  = rx_s;
                if (rx_bit_end) rx_state_n = RX_STOP;
            end
            RX_STOP: begin
                if (rx_sample) begin
                    rx_state_n = RX_IDLE;
                    rx_tick_n  = '0;
                    set_frame  = !rx_s;
                    set_par    = (rx_mode != PAR_NONE) &&
                                 (rx_pbit != parity_bit(rx_mode, ^rx_shift));
                    if (rx_full && !rx_pop) set_ovr = 1'b1;
                    else                    rx_push = 1'b1;
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    // A new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            err_parity  <= 1'b0;
            err_frame   <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            err_parity  <= set_par   | (err_parity  & ~err_clr);
            err_frame   <= set_frame | (err_frame   & ~err_clr);
            err_overrun <= set_ovr   | (err_overrun & ~err_clr);
        end
    end

endmodule

// File: tb/tb_uart_core_p.sv
// Directed self-checking bench for uart_core_p (default parameters, cfg_div=0 for 16-clock bits).
// Flow-control checks are included when UART_FLOW_CTRL_EN is defined.
module tb_uart_core_p;

    logic        Clk;
    logic        Rst;
    logic [15:0] cfg_div;
    logic [1:0]  cfg_parity;
    logic        cfg_stop2;
    logic        cfg_loop;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [4:0]  tx_count;
    logic [4:0]  rx_count;
    logic        tx_idle;
    logic        err_parity;
    logic        err_frame;
    logic        err_overrun;
    logic        err_clr;
    logic        cts_n;
    logic        rts_n;
    logic        TX;
    logic        RX;

    int total = 0;
    int bad   = 0;

    uart_core_p dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .cfg_div     (cfg_div),
        .cfg_parity  (cfg_parity),
        .cfg_stop2   (cfg_stop2),
        .cfg_loop    (cfg_loop),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .tx_count    (tx_count),
        .rx_count    (rx_count),
        .tx_idle     (tx_idle),
        .err_parity  (err_parity),
        .err_frame   (err_frame),
        .err_overrun (err_overrun),
        .err_clr     (err_clr),
`ifdef UART_FLOW_CTRL_EN
        .cts_n       (cts_n),
        .rts_n       (rts_n),
`endif
        .TX          (TX),
        .RX          (RX)
    );

`ifndef UART_FLOW_CTRL_EN
    assign rts_n = 1'b1;
`endif

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic do_reset();
        Rst = 1'b1;
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
    endtask

    task automatic push_byte(input logic [7:0] b);
        int n = 0;
        while (!tx_ready && n < 1000) begin
            @(negedge Clk);
            n++;
        end
        total++;
        if (!tx_ready) begin
            bad++;
            $display("[TB] FAIL push_wait: tx_ready got %b want 1 after %0d cycles", tx_ready, n);
        end else begin
            tx_data  = b;
            tx_valid = 1'b1;
            @(negedge Clk);
            tx_valid = 1'b0;
        end
    endtask

    task automatic drive_rx(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            RX = bits[i];
            repeat (16) @(negedge Clk);
        end
        RX = 1'b1;
        repeat (20) @(negedge Clk);
    endtask

    task automatic test_reset();
        cfg_div = 16'd0; cfg_parity = 2'b00; cfg_loop = 1'b0;
        do_reset();
        total++; if (TX !== 1'b1)        begin bad++; $display("[TB] FAIL reset_tx: got %b want 1", TX); end
        total++; if (tx_ready !== 1'b1)  begin bad++; $display("[TB] FAIL reset_tx_ready: got %b want 1", tx_ready); end
        total++; if (rx_valid !== 1'b0)  begin bad++; $display("[TB] FAIL reset_rx_valid: got %b want 0", rx_valid); end
        total++; if (tx_count !== 5'd0)  begin bad++; $display("[TB] FAIL reset_tx_count: got %0d want 0", tx_count); end
        total++; if (rx_count !== 5'd0)  begin bad++; $display("[TB] FAIL reset_rx_count: got %0d want 0", rx_count); end
        total++; if (tx_idle !== 1'b1)   begin bad++; $display("[TB] FAIL reset_tx_idle: got %b want 1", tx_idle); end
        total++; if ({err_parity, err_frame, err_overrun} !== 3'b000)
            begin bad++; $display("[TB] FAIL reset_errs: got %b want 000", {err_parity, err_frame, err_overrun}); end
    endtask

    task automatic test_tx_frame();
        logic        wave [0:176];
        logic        idle [0:176];
        logic [10:0] exp_bits;
        int          n = 0;
        cfg_div = 16'd0; cfg_parity = 2'b01; cfg_stop2 = 1'b0; cfg_loop = 1'b0;
        do_reset();
        push_byte(8'h55);
        while (TX !== 1'b0 && n < 40) begin
            @(negedge Clk);
            n++;
        end
        total++;
        if (TX !== 1'b0) begin
            bad++;
            $display("[TB] FAIL tx_start_timeout: TX got %b want 0", TX);
        end else begin
            for (int i = 0; i <= 176; i++) begin
                wave[i] = TX;
                idle[i] = tx_idle;
                @(negedge Clk);
            end
            // stop 1, odd parity 1, data 0x55 LSB first, start 0
            exp_bits = {1'b1, 1'b1, 8'h55, 1'b0};
            for (int k = 0; k < 11; k++) begin
                total++;
                if (wave[k*16+8] !== exp_bits[k]) begin
                    bad++;
                    $display("[TB] FAIL tx_bit%0d: got %b want %b", k, wave[k*16+8], exp_bits[k]);
                end
            end
            total++; if (wave[15] !== 1'b0) begin bad++; $display("[TB] FAIL tx_start_len15: got %b want 0", wave[15]); end
            total++; if (wave[16] !== 1'b1) begin bad++; $display("[TB] FAIL tx_start_len16: got %b want 1", wave[16]); end
            total++; if (idle[175] !== 1'b0) begin bad++; $display("[TB] FAIL tx_idle_175: got %b want 0", idle[175]); end
            total++; if (idle[176] !== 1'b1) begin bad++; $display("[TB] FAIL tx_idle_176: got %b want 1", idle[176]); end
        end
    endtask

    task automatic test_tx_full();
        cfg_div = 16'd1000; cfg_parity = 2'b00; cfg_loop = 1'b0;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            tx_data  = 8'(i);
            tx_valid = 1'b1;
            @(negedge Clk);
        end
        tx_valid = 1'b0;
        total++; if (tx_count !== 5'd16) begin bad++; $display("[TB] FAIL full_count: got %0d want 16", tx_count); end
        total++; if (tx_ready !== 1'b0)  begin bad++; $display("[TB] FAIL full_ready: got %b want 0", tx_ready); end
        total++; if (tx_idle !== 1'b0)   begin bad++; $display("[TB] FAIL full_idle: got %b want 0", tx_idle); end
        cfg_div = 16'd0;
    endtask

    task automatic test_loopback();
        int   n = 0;
        int   peak = 0;
        logic tx_dropped = 1'b0;
        cfg_div = 16'd0; cfg_parity = 2'b01; cfg_loop = 1'b1; rx_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 10; i++) push_byte(8'(i));
        while (rx_count != 5'd10 && n < 3000) begin
            if (TX !== 1'b1) tx_dropped = 1'b1;
            if (int'(rx_count) > peak) peak = int'(rx_count);
            @(negedge Clk);
            n++;
        end
        if (int'(rx_count) > peak) peak = int'(rx_count);
        total++; if (rx_count !== 5'd10) begin bad++; $display("[TB] FAIL loop_count: got %0d want 10", rx_count); end
        total++; if (peak > 10)          begin bad++; $display("[TB] FAIL loop_peak: got %0d want <=10", peak); end
        total++; if (tx_dropped !== 1'b0) begin bad++; $display("[TB] FAIL loop_tx_pin: low seen got %b want 0", tx_dropped); end
        total++; if ({err_parity, err_frame, err_overrun} !== 3'b000)
            begin bad++; $display("[TB] FAIL loop_errs: got %b want 000", {err_parity, err_frame, err_overrun}); end
        for (int i = 0; i < 10; i++) begin
            total++;
            if (rx_valid !== 1'b1 || rx_data !== 8'(i)) begin
                bad++;
                $display("[TB] FAIL loop_data%0d: got valid=%b data=%h want valid=1 data=%h", i, rx_valid, rx_data, 8'(i));
            end
            rx_ready = 1'b1;
            @(negedge Clk);
        end
        rx_ready = 1'b0;
        total++; if (rx_count !== 5'd0) begin bad++; $display("[TB] FAIL loop_drain: got %0d want 0", rx_count); end
        cfg_loop = 1'b0;
    endtask

    task automatic test_overrun();
        int n = 0;
        cfg_div = 16'd0; cfg_parity = 2'b00; cfg_loop = 1'b1; rx_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 20; i++) push_byte(8'(i));
        while (!tx_idle && n < 4000) begin
            @(negedge Clk);
            n++;
        end
        repeat (40) @(negedge Clk);
        total++; if (tx_idle !== 1'b1)    begin bad++; $display("[TB] FAIL ovr_tx_done: got %b want 1", tx_idle); end
        total++; if (rx_count !== 5'd16)  begin bad++; $display("[TB] FAIL ovr_count: got %0d want 16", rx_count); end
        total++; if (err_overrun !== 1'b1) begin bad++; $display("[TB] FAIL ovr_flag: got %b want 1", err_overrun); end
        total++; if ({err_parity, err_frame} !== 2'b00)
            begin bad++; $display("[TB] FAIL ovr_other_errs: got %b want 00", {err_parity, err_frame}); end
        err_clr = 1'b1;
        @(negedge Clk);
        err_clr = 1'b0;
        total++; if (err_overrun !== 1'b0) begin bad++; $display("[TB] FAIL ovr_clear: got %b want 0", err_overrun); end
        for (int i = 0; i < 16; i++) begin
            total++;
            if (rx_data !== 8'(i)) begin
                bad++;
                $display("[TB] FAIL ovr_data%0d: got %h want %h", i, rx_data, 8'(i));
            end
            rx_ready = 1'b1;
            @(negedge Clk);
        end
        rx_ready = 1'b0;
        total++; if (rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL ovr_dropped: rx_valid got %b want 0", rx_valid); end
        cfg_loop = 1'b0;
    endtask

    task automatic test_rx_errors();
        cfg_div = 16'd0; cfg_parity = 2'b00; cfg_loop = 1'b0; RX = 1'b1;
        do_reset();
        // start 0, 0xA3, stop 0
        drive_rx(16'h0146, 10);
        total++; if (rx_count !== 5'd1)   begin bad++; $display("[TB] FAIL frame_count: got %0d want 1", rx_count); end
        total++; if (rx_data !== 8'hA3)   begin bad++; $display("[TB] FAIL frame_data: got %h want a3", rx_data); end
        total++; if (err_frame !== 1'b1)  begin bad++; $display("[TB] FAIL frame_flag: got %b want 1", err_frame); end
        total++; if (err_parity !== 1'b0) begin bad++; $display("[TB] FAIL frame_no_par: got %b want 0", err_parity); end
        err_clr = 1'b1;
        @(negedge Clk);
        err_clr = 1'b0;
        total++; if (err_frame !== 1'b0)  begin bad++; $display("[TB] FAIL frame_clear: got %b want 0", err_frame); end
        // even parity: 0xA3 has four 1s so the correct bit is 0; send 1
        cfg_parity = 2'b10;
        drive_rx(16'h0746, 11);
        total++; if (err_parity !== 1'b1) begin bad++; $display("[TB] FAIL par_flag: got %b want 1", err_parity); end
        total++; if (err_frame !== 1'b0)  begin bad++; $display("[TB] FAIL par_no_frame: got %b want 0", err_frame); end
        total++; if (rx_count !== 5'd2)   begin bad++; $display("[TB] FAIL par_count: got %0d want 2", rx_count); end
        total++; if (rx_data !== 8'hA3)   begin bad++; $display("[TB] FAIL par_head: got %h want a3", rx_data); end
        cfg_parity = 2'b00;
    endtask

    task automatic test_glitch();
        cfg_div = 16'd0; cfg_parity = 2'b00; cfg_loop = 1'b0; RX = 1'b1;
        do_reset();
        RX = 1'b0;
        repeat (4) @(negedge Clk);
        RX = 1'b1;
        repeat (60) @(negedge Clk);
        total++; if (rx_count !== 5'd0) begin bad++; $display("[TB] FAIL glitch_count: got %0d want 0", rx_count); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL glitch_valid: got %b want 0", rx_valid); end
        total++; if ({err_parity, err_frame, err_overrun} !== 3'b000)
            begin bad++; $display("[TB] FAIL glitch_errs: got %b want 000", {err_parity, err_frame, err_overrun}); end
        // start 0, 0x3C, stop 1
        drive_rx(16'h0278, 10);
        total++; if (rx_count !== 5'd1)  begin bad++; $display("[TB] FAIL glitch_next_count: got %0d want 1", rx_count); end
        total++; if (rx_data !== 8'h3C)  begin bad++; $display("[TB] FAIL glitch_next_data: got %h want 3c", rx_data); end
        total++; if (err_frame !== 1'b0) begin bad++; $display("[TB] FAIL glitch_next_frame: got %b want 0", err_frame); end
    endtask

    task automatic test_reset_midframe();
        int   n = 0;
        logic went_low = 1'b0;
        cfg_div = 16'd0; cfg_parity = 2'b00; cfg_loop = 1'b0;
        do_reset();
        push_byte(8'hFF);
        push_byte(8'hFF);
        while (TX !== 1'b0 && n < 40) begin
            @(negedge Clk);
            n++;
        end
        total++; if (TX !== 1'b0)       begin bad++; $display("[TB] FAIL mid_started: TX got %b want 0", TX); end
        total++; if (tx_count !== 5'd1) begin bad++; $display("[TB] FAIL mid_pending: got %0d want 1", tx_count); end
        repeat (5) @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        total++; if (TX !== 1'b1)       begin bad++; $display("[TB] FAIL mid_tx: got %b want 1", TX); end
        total++; if (tx_count !== 5'd0) begin bad++; $display("[TB] FAIL mid_count: got %0d want 0", tx_count); end
        total++; if (tx_ready !== 1'b1) begin bad++; $display("[TB] FAIL mid_ready: got %b want 1", tx_ready); end
        total++; if (tx_idle !== 1'b1)  begin bad++; $display("[TB] FAIL mid_idle: got %b want 1", tx_idle); end
        Rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (TX !== 1'b1) went_low = 1'b1;
            @(negedge Clk);
        end
        total++; if (went_low !== 1'b0) begin bad++; $display("[TB] FAIL mid_aborted: low seen got %b want 0", went_low); end
`ifdef UART_FLOW_CTRL_EN
        cts_n = 1'b1;
        do_reset();
        push_byte(8'h12);
        went_low = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (TX !== 1'b1) went_low = 1'b1;
            @(negedge Clk);
        end
        total++; if (went_low !== 1'b0) begin bad++; $display("[TB] FAIL cts_block: low seen got %b want 0", went_low); end
        total++; if (tx_count !== 5'd1) begin bad++; $display("[TB] FAIL cts_held: got %0d want 1", tx_count); end
        total++; if (rts_n !== 1'b0)    begin bad++; $display("[TB] FAIL rts_low: got %b want 0", rts_n); end
        cts_n = 1'b0;
        n = 0;
        while (TX !== 1'b0 && n < 20) begin
            @(negedge Clk);
            n++;
        end
        total++; if (TX !== 1'b0) begin bad++; $display("[TB] FAIL cts_release: TX got %b want 0", TX); end
`endif
    endtask

    initial begin
        Rst = 1'b1; cfg_div = 16'd0; cfg_parity = 2'b00; cfg_stop2 = 1'b0; cfg_loop = 1'b0;
        tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0; err_clr = 1'b0; cts_n = 1'b0; RX = 1'b1;
        @(negedge Clk);
        $display("[TB] starting uart_core_p bench");
        test_reset();
        test_tx_frame();
        test_tx_full();
        test_loopback();
        test_overrun();
        test_rx_errors();
        test_glitch();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
